// File: rtl/action_conditioner.sv
// action_conditioner
//   Turns two raw, bouncy move buttons into one move command per video frame.
//   Each button is synchronized, debounced and edge-detected. A press, or an
//   auto-repeat while the button is held, sets a per-button pending bit. At
//   each frame boundary (vsync rising edge) the pending bits are transferred
//   to the registered actions output and then cleared.
//
// Parameters
//   DEBOUNCE_CYCLES  equal samples needed to accept a level change (1..65535)
//   REPEAT_DELAY     held frames before the first auto-repeat      (1..63)
//   REPEAT_RATE      frames between later auto-repeats             (1..63)
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   synchronous, active-high reset
//   btn_right   in   raw asynchronous right button, active-high
//   btn_left    in   raw asynchronous left button, active-high
//   vsync       in   frame sync, synchronous to clock
//   actions     out  [0]=right, [1]=left; held for one whole frame
//   frame_tick  out  one-cycle pulse in the cycle actions updates
module action_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 12,
  parameter int REPEAT_RATE     = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_right,
  input  logic       btn_left,
  input  logic       vsync,
  output logic [1:0] actions,
  output logic       frame_tick
);

  localparam logic [15:0] DB_TC = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [5:0]  RPT_DELAY = 6'(REPEAT_DELAY);
  // Reload value after a repeat, so the next repeat comes REPEAT_RATE frames
  // later without the counter ever running past REPEAT_DELAY. A rate longer
  // than the delay cannot be expressed this way and degrades to period DELAY.
  localparam logic [5:0]  RPT_RELOAD = (REPEAT_RATE >= REPEAT_DELAY) ? 6'd0
                                       : 6'(REPEAT_DELAY - REPEAT_RATE);

  // Bit 0 is the right button, bit 1 the left, matching actions.
  logic [1:0]       btn_raw;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       deb_q, deb_d;
  logic [1:0]       deb_prev_q;
  logic [1:0][15:0] db_cnt_q, db_cnt_d;
  logic [1:0][5:0]  held_q, held_d;
  logic [1:0][5:0]  held_inc;
  logic [1:0]       rise;
  logic [1:0]       rpt;
  logic [1:0]       pend_q, pend_d;
  logic             vsync_q;
  logic             boundary;
  logic [1:0]       actions_q, actions_d;
  logic             frame_tick_q;

  assign btn_raw  = {btn_left, btn_right};
  assign boundary = vsync & ~vsync_q;
  assign rise     = deb_q & ~deb_prev_q;

  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = db_cnt_q;
    held_d   = held_q;
    held_inc = '0;
    rpt      = '0;
    for (int b = 0; b < 2; b++) begin
      // Debounce: count consecutive samples that disagree with the accepted
      // level; any agreeing sample restarts the count.
      if (sync2_q[b] == deb_q[b]) begin
        db_cnt_d[b] = '0;
      end else if (db_cnt_q[b] == DB_TC) begin
        deb_d[b]    = sync2_q[b];
        db_cnt_d[b] = '0;
      end else begin
        db_cnt_d[b] = db_cnt_q[b] + 16'd1;
      end

      // Held-frame counter for auto-repeat.
      held_inc[b] = held_q[b] + 6'd1;
      if (!deb_q[b]) begin
        held_d[b] = '0;
      end else if (boundary) begin
        if (held_inc[b] == RPT_DELAY) begin
          rpt[b]    = 1'b1;
          held_d[b] = RPT_RELOAD;
        end else begin
          held_d[b] = held_inc[b];
        end
      end
    end

    // A set arriving in the boundary cycle survives the clear and is
    // reported in the following frame.
    if (boundary) begin
      pend_d = rise | rpt;
    end else begin
      pend_d = pend_q | rise | rpt;
    end

    // Simultaneous left and right cancel each other.
    actions_d = actions_q;
    if (boundary) begin
      actions_d = (pend_q == 2'b11) ? 2'b00 : pend_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      deb_q        <= '0;
      deb_prev_q   <= '0;
      db_cnt_q     <= '0;
      held_q       <= '0;
      pend_q       <= '0;
      vsync_q      <= 1'b0;
      actions_q    <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      deb_q        <= deb_d;
      deb_prev_q   <= deb_q;
      db_cnt_q     <= db_cnt_d;
      held_q       <= held_d;
      pend_q       <= pend_d;
      vsync_q      <= vsync;
      actions_q    <= actions_d;
      frame_tick_q <= boundary;
    end
  end

  assign actions    = actions_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_action_conditioner.sv
// Directed bench for action_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=3, REPEAT_RATE=2. Inputs change on the falling edge, outputs
// are sampled on the falling edge.
module tb_action_conditioner;

  logic       clock;
  logic       reset;
  logic       btn_right;
  logic       btn_left;
  logic       vsync;
  logic [1:0] actions;
  logic       frame_tick;

  int n_checks;
  int n_fail;

  action_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(3),
    .REPEAT_RATE(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .btn_right(btn_right),
    .btn_left(btn_left),
    .vsync(vsync),
    .actions(actions),
    .frame_tick(frame_tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Raise vsync for one boundary, check the tick and the loaded actions,
  // then check the tick lasts one cycle and actions holds.
  task automatic frame(input string tag, input logic [1:0] exp_act);
    @(negedge clock) vsync = 1'b1;
    @(negedge clock);
    check_eq({tag, "_tick"}, frame_tick, 1);
    check_eq(tag, actions, exp_act);
    vsync = 1'b0;
    @(negedge clock);
    check_eq({tag, "_tick_end"}, frame_tick, 0);
    check_eq({tag, "_hold"}, actions, exp_act);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    btn_right = 1'b0;
    btn_left  = 1'b0;
    vsync     = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("rst_actions", actions, 0);
    check_eq("rst_tick", frame_tick, 0);
    check_eq("rst_pend", dut.pend_q, 0);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check_eq("idle_tick", frame_tick, 0);
    frame("first_frame", 2'b00);

    // 3-cycle glitch is rejected.
    btn_right = 1'b1;
    repeat (3) @(negedge clock);
    btn_right = 1'b0;
    repeat (10) @(negedge clock);
    check_eq("glitch_pend", dut.pend_q, 0);
    frame("glitch", 2'b00);

    // 4-cycle pulse is exactly enough.
    btn_right = 1'b1;
    repeat (4) @(negedge clock);
    btn_right = 1'b0;
    repeat (10) @(negedge clock);
    check_eq("pulse4_pend", dut.pend_q, 1);
    frame("pulse4", 2'b01);
    frame("pulse4_next", 2'b00);

    // Held 10 cycles and released inside one frame; release keeps pending.
    btn_right = 1'b1;
    repeat (10) @(negedge clock);
    btn_right = 1'b0;
    repeat (10) @(negedge clock);
    check_eq("hold10_pend", dut.pend_q, 1);
    check_eq("hold10_deb", dut.deb_q, 0);
    frame("hold10", 2'b01);
    frame("hold10_next", 2'b00);

    // Both pressed in one frame cancel.
    btn_right = 1'b1;
    btn_left  = 1'b1;
    repeat (10) @(negedge clock);
    btn_right = 1'b0;
    btn_left  = 1'b0;
    repeat (10) @(negedge clock);
    check_eq("both_pend", dut.pend_q, 2'b11);
    frame("both", 2'b00);
    check_eq("both_pend_clr", dut.pend_q, 0);
    frame("both_next", 2'b00);

    // Press becomes pending in the very boundary cycle.
    @(negedge clock) btn_right = 1'b1;
    repeat (6) @(posedge clock);
    @(negedge clock) vsync = 1'b1;
    @(negedge clock);
    check_eq("edge_tick", frame_tick, 1);
    check_eq("edge_act", actions, 2'b00);
    check_eq("edge_pend", dut.pend_q, 1);
    vsync     = 1'b0;
    btn_right = 1'b0;
    repeat (10) @(negedge clock);
    frame("edge_next", 2'b01);
    frame("edge_after", 2'b00);

    // Auto-repeat on left: frames 1,4,6,8,10 carry the move.
    btn_left = 1'b1;
    repeat (10) @(negedge clock);
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) repeat (8) @(negedge clock);
      frame($sformatf("rpt_f%0d", k),
            (k == 1 || k == 4 || k == 6 || k == 8 || k == 10) ? 2'b10 : 2'b00);
      if (k == 10) btn_left = 1'b0;
    end
    check_eq("rpt_held_clr", dut.held_q, 0);

    // Reset two cycles after a press becomes pending, vsync high mid-frame.
    btn_right = 1'b1;
    repeat (7) @(negedge clock);
    check_eq("rstmid_pend", dut.pend_q, 1);
    repeat (2) @(negedge clock);
    reset     = 1'b1;
    btn_right = 1'b0;
    vsync     = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("rstmid_act", actions, 0);
    check_eq("rstmid_tick", frame_tick, 0);
    check_eq("rstmid_pend0", dut.pend_q, 0);
    check_eq("rstmid_deb", dut.deb_q, 0);
    check_eq("rstmid_dbcnt", dut.db_cnt_q, 0);
    check_eq("rstmid_held", dut.held_q, 0);
    vsync = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    check_eq("rstmid_notick", frame_tick, 0);
    repeat (10) @(negedge clock);
    frame("rstmid_frame", 2'b00);

    // Button held through reset yields exactly one press afterwards.
    btn_right = 1'b1;
    reset     = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_eq("rsthold_deb", dut.deb_q, 0);
    repeat (10) @(negedge clock);
    frame("rsthold", 2'b01);
    btn_right = 1'b0;
    repeat (10) @(negedge clock);
    frame("rsthold_next", 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
